// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared FSM states, datapath widths and saturation helper for pid_seq
// Contents:
//   state_t     sequencer states IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM
//   EW, DW      error and error-difference widths (signed)
//   MUL_CYCLES  iterations of the shared shift-add multiplier
//   saturate()  clamps an integer into [lo, hi]
package pid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ERR,
      MUL_P,
      MUL_I,
      MUL_D,
      SUM
   } state_t;

   localparam int EW         = 5;
   localparam int DW         = 6;
   localparam int MUL_CYCLES = 4;

   function automatic int saturate(input int v, input int lo, input int hi);
      if (v < lo) begin
         return lo;
      end else if (v > hi) begin
         return hi;
      end
      return v;
   endfunction

endpackage

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - 4-cycle shift-add multiplier, signed multiplicand by 4-bit unsigned gain
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   clear        synchronous abort: drops busy/done
//   start        loads mcand/gain and performs iteration 0 on the same edge
//   mcand        signed multiplicand, W bits
//   gain         unsigned 4-bit multiplier
//   product      signed W+4 bit result, held until the next start
//   busy         iterations 1..3 in progress
//   done         one-cycle pulse, product final (4 cycles after the start cycle)
module shift_add_mul
   import pid_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                start,
   input  logic signed [W-1:0] mcand,
   input  logic [3:0]          gain,
   output logic signed [W+3:0] product,
   output logic                busy,
   output logic                done
);

   logic signed [W+3:0] mcand_x;
   logic signed [W+3:0] mcand_q;
   logic signed [W+3:0] acc_q;
   logic [3:0]          gain_q;
   logic [1:0]          cnt_q;
   logic                busy_q;
   logic                done_q;

   assign mcand_x = {{4{mcand[W-1]}}, mcand};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_q <= '0;
         acc_q   <= '0;
         gain_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (clear) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (start) begin
         mcand_q <= mcand_x;
         gain_q  <= gain;
         acc_q   <= gain[0] ? mcand_x : '0;
         cnt_q   <= 2'd1;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else if (busy_q) begin
         if (gain_q[cnt_q]) begin
            acc_q <= acc_q + (mcand_q <<< cnt_q);
         end
         cnt_q <= cnt_q + 2'd1;
         if (cnt_q == 2'(MUL_CYCLES - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   assign product = acc_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: rtl/pid_seq.sv
// rtl/pid_seq.sv - sequential PID core sharing one shift-add multiplier across P, I and D
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   enable              low = synchronous hold (IDLE, acc/e_prev/stimulus cleared)
//   pv_stb              new-sample strobe, accepted only in IDLE
//   sp, pv, kp, ki, kd  setpoint, process value and gains, latched with pv_stb
//   stimulus            saturated 4-bit output, registered
//   done                one-cycle pulse with each new stimulus (15th edge after accept)
//   busy                sequence in progress
// Build option: PID_ANTIWINDUP_EN freezes the integrator while the last output
// was clamped in the direction of the current error.
module pid_seq
   import pid_pkg::*;
#(
   parameter int IW    = 8,
   parameter int SHIFT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       pv_stb,
   input  logic [3:0] sp,
   input  logic [3:0] pv,
   input  logic [3:0] kp,
   input  logic [3:0] ki,
   input  logic [3:0] kd,
   output logic [3:0] stimulus,
   output logic       done,
   output logic       busy
);

   localparam int PW      = IW + 4;
   localparam int SW      = IW + 6;
   localparam int ACC_MAX = 2 ** (IW - 1) - 1;
   localparam int ACC_MIN = -(2 ** (IW - 1));
   localparam logic signed [SW-1:0] Y_MAX = 15;

   state_t               state_q, state_d;
   logic [3:0]           sp_q, pv_q, kp_q, ki_q, kd_q;
   logic signed [EW-1:0] e_w, e_prev_q;
   logic signed [DW-1:0] d_w, d_q;
   logic signed [IW-1:0] acc_w, acc_q;
   logic signed [PW-1:0] p_q, i_q, product;
   logic signed [SW-1:0] s_w, y_w;
   logic [3:0]           stim_w, stim_q;
   logic                 done_q;
   logic                 acc_hold;
   logic                 mul_start, mul_busy, mul_done;
   logic signed [IW-1:0] mcand;
   logic [3:0]           gain;

   assign e_w   = $signed({1'b0, sp_q}) - $signed({1'b0, pv_q});
   assign d_w   = {e_w[EW-1], e_w} - {e_prev_q[EW-1], e_prev_q};
   assign acc_w = IW'(saturate(int'(acc_q) + int'(e_w), ACC_MIN, ACC_MAX));

`ifdef PID_ANTIWINDUP_EN
   logic sat_hi_q, sat_lo_q;
   assign acc_hold = (sat_hi_q && !e_w[EW-1] && (e_w != '0)) || (sat_lo_q && e_w[EW-1]);
`else
   assign acc_hold = 1'b0;
`endif

   // D product is read straight from the multiplier; it stays put through SUM.
   assign s_w = {{2{p_q[PW-1]}}, p_q} + {{2{i_q[PW-1]}}, i_q} + {{2{product[PW-1]}}, product};
   assign y_w = s_w >>> SHIFT;

   always_comb begin
      stim_w = y_w[3:0];
      if (y_w[SW-1]) begin
         stim_w = 4'd0;
      end else if (y_w > Y_MAX) begin
         stim_w = 4'd15;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The next multiply is launched in the cycle the previous one reports done,
   // so its operands are selected from the state being left.
   always_comb begin
      state_d   = state_q;
      mul_start = 1'b0;
      mcand     = '0;
      gain      = '0;
      case (state_q)
         IDLE: begin
            if (pv_stb) state_d = ERR;
         end
         ERR: begin
            state_d = MUL_P;
         end
         MUL_P: begin
            if (mul_done) begin
               state_d   = MUL_I;
               mul_start = 1'b1;
               mcand     = acc_q;
               gain      = ki_q;
            end else if (!mul_busy) begin
               mul_start = 1'b1;
               mcand     = {{(IW - EW){e_prev_q[EW-1]}}, e_prev_q};
               gain      = kp_q;
            end
         end
         MUL_I: begin
            if (mul_done) begin
               state_d   = MUL_D;
               mul_start = 1'b1;
               mcand     = {{(IW - DW){d_q[DW-1]}}, d_q};
               gain      = kd_q;
            end
         end
         MUL_D: begin
            if (mul_done) state_d = SUM;
         end
         SUM: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (!enable) begin
         state_d   = IDLE;
         mul_start = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp_q     <= '0;
         pv_q     <= '0;
         kp_q     <= '0;
         ki_q     <= '0;
         kd_q     <= '0;
         e_prev_q <= '0;
         d_q      <= '0;
         acc_q    <= '0;
         p_q      <= '0;
         i_q      <= '0;
         stim_q   <= '0;
         done_q   <= 1'b0;
      end else if (!enable) begin
         e_prev_q <= '0;
         acc_q    <= '0;
         stim_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pv_stb) begin
                  sp_q <= sp;
                  pv_q <= pv;
                  kp_q <= kp;
                  ki_q <= ki;
                  kd_q <= kd;
               end
            end
            ERR: begin
               e_prev_q <= e_w;
               d_q      <= d_w;
               if (!acc_hold) acc_q <= acc_w;
            end
            MUL_P: begin
               if (mul_done) p_q <= product;
            end
            MUL_I: begin
               if (mul_done) i_q <= product;
            end
            SUM: begin
               stim_q <= stim_w;
               done_q <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef PID_ANTIWINDUP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sat_hi_q <= 1'b0;
         sat_lo_q <= 1'b0;
      end else if (!enable) begin
         sat_hi_q <= 1'b0;
         sat_lo_q <= 1'b0;
      end else if (state_q == SUM) begin
         sat_hi_q <= !y_w[SW-1] && (y_w > Y_MAX);
         sat_lo_q <= y_w[SW-1];
      end
   end
`endif

   shift_add_mul #(
      .W (IW)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .clear   (!enable),
      .start   (mul_start),
      .mcand   (mcand),
      .gain    (gain),
      .product (product),
      .busy    (mul_busy),
      .done    (mul_done)
   );

   assign stimulus = stim_q;
   assign done     = done_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: doc/pid_seq.md
Name: pid_seq

Overview:
- Area-lean PID core between the process-value SPI input stage (supplies pv plus a strobe on each new sample) and the stimulus SPI output stage (consumes stimulus plus a done strobe).
- One 4-bit shift-add multiplier is shared across P, I and D over a fixed 15-cycle sequence, instead of three parallel multipliers.
- Output is a saturated 4-bit unsigned stimulus.

Parameters:
- IW, 8: integral accumulator width, signed, saturating.
- SHIFT, 2: arithmetic right shift applied to the P+I+D sum before output saturation.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; all registers cleared while low.
- enable  in  1  high = run. Low = synchronous hold: FSM to IDLE, accumulator, e_prev and stimulus cleared.
- pv_stb  in  1  one-cycle pulse: a new pv is valid.
- sp  in  4  setpoint, unsigned.
- pv  in  4  process value, unsigned; sampled on the edge that accepts pv_stb.
- kp, ki, kd  in  4 each  gains, unsigned; sampled together with pv.
- stimulus  out  4  controller output, unsigned, registered.
- done  out  1  one-cycle pulse; asserted in the same cycle stimulus takes its new value.
- busy  out  1  high from the cycle after pv_stb is accepted until done.

Behaviour:
- Reset values: stimulus=0, done=0, busy=0, acc=0, e_prev=0, FSM=IDLE.
- IDLE:
  - pv_stb && enable -> latch sp, pv, kp, ki, kd -> go to ERR.
  - pv_stb while not IDLE is ignored; it is not queued.
- ERR (1 cycle):
  - e = sp - pv, signed 5-bit, range -15..15.
  - d = e - e_prev, signed 6-bit.
  - acc = sat_IW(acc + e), clamped to -2^(IW-1)..2^(IW-1)-1.
  - e_prev <= e.
- MUL_P, MUL_I, MUL_D (4 cycles each): shared multiplier forms kp*e, ki*acc, kd*d in turn.
  - Algorithm: iteration i adds multiplicand<<i when bit i of the gain is set.
  - Multiplicand is sign-extended; product width is IW+4.
- SUM (1 cycle):
  - s = P + I + D, signed, width IW+6.
  - y = s >>> SHIFT.
  - stimulus <= 0 if y<0, 15 if y>15, else y.
  - done pulses; return to IDLE.
- Latency: stimulus and done update on the 15th rising edge after the edge that accepts pv_stb. A new pv_stb is accepted on the same edge that done is asserted (state is IDLE then? no): it is accepted on the first edge after done.
- enable low mid-sequence: the sequence aborts on the next edge; stimulus=0; no done pulse.
- reset low mid-sequence: everything clears immediately (asynchronous).

Optional Feature:
- Macro: PID_ANTIWINDUP_EN.
- Defined: in ERR, acc is not updated when the previous output saturated in the direction of e. That is, skip the update when the last stimulus was clamped at 15 and e>0, or clamped at 0 and e<0. One sat_hi/sat_lo flag pair is registered in SUM.
- Undefined: acc always updates, subject only to the IW clamp.

Decomposition:
- Package pid_pkg holds:
  - FSM state enum (IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM);
  - localparams EW=5, DW=6, MUL_CYCLES=4;
  - a saturate function.
- Sub-module shift_add_mul: signed multiplicand, 4-bit unsigned gain, start/done, 4-cycle fixed latency. It is instantiated once.

Test Plan:
- Proportional: SHIFT=2, sp=10, pv=6, kp=4, ki=kd=0, one strobe -> stimulus=4, with done exactly 15 cycles after the strobe.
- Integral: kp=kd=0, ki=2, sp=9, pv=6, three strobes -> stimulus 1, 3, 4 (acc 3, 6, 9).
- Derivative: kd=4, kp=ki=0, sp=5, pv=0, two strobes from reset -> stimulus 5, then 0.
- Saturation: kp=15, sp=15, pv=0 -> 15. Then sp=0, pv=15 -> 0. Then 9 strobes with ki=15, e=15 -> acc clamps at 127.
- Strobe while busy: second pv_stb 5 cycles after the first -> ignored, a single done pulse. Then enable low at cycle 8 -> no done pulse, stimulus=0, acc=0.
- Anti-windup (PID_ANTIWINDUP_EN defined): ki=15, e=15, repeated strobes -> acc stops at 15 once the output saturates. With the macro undefined, acc reaches 127.
